// File: rtl/csa_seq_adder_pkg.sv
// Shared definitions for the chunk-serial wide adder: FSM encoding and the
// width helper for the chunk index counter.
package csa_seq_adder_pkg;

   // state   | meaning
   // IDLE    | waiting for start; outputs hold last result
   // RUN     | one chunk added per clock, LSB chunk first
   // DONE    | single-cycle result-valid pulse; may accept the next start
   // (2'd3)  | unreachable; decoded back to IDLE
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Index counter width; a single-chunk build still needs a 1-bit counter.
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/csa_seq_adder_csa.sv
// N-bit conditional-sum adder. Every bit starts with both candidate results
// (carry-in 0 and carry-in 1); blocks of doubling size are merged, the lower
// block's candidate carries choosing the upper block's candidates. The real
// carry-in selects the final pair at the end.
module csa_seq_adder_csa #(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         ci,
   output logic [N-1:0] sum,
   output logic         co
);

   // c0/c1 hold the carry-out of the block whose lowest bit is the index.
   logic [N-1:0] s0;
   logic [N-1:0] s1;
   logic [N-1:0] c0;
   logic [N-1:0] c1;
   logic         nc0;
   logic         nc1;

   // Log-depth merge of candidate sums/carries, then final carry-in select.
   always_comb begin
      s0  = a ^ b;
      s1  = ~(a ^ b);
      c0  = a & b;
      c1  = a | b;
      nc0 = 1'b0;
      nc1 = 1'b0;
      for (int k = 1; k < N; k = k * 2) begin
         for (int j = 0; j < N; j = j + 2 * k) begin
            if (j + k < N) begin
               for (int i = j + k; i < j + 2 * k; i++) begin
                  if (i < N) begin
                     s0[i] = c0[j] ? s1[i] : s0[i];
                     s1[i] = c1[j] ? s1[i] : s0[i];
                  end
               end
               nc0   = c0[j] ? c1[j+k] : c0[j+k];
               nc1   = c1[j] ? c1[j+k] : c0[j+k];
               c0[j] = nc0;
               c1[j] = nc1;
            end
         end
      end
      sum = ci ? s1 : s0;
      co  = ci ? c1[0] : c0[0];
   end

endmodule

// File: rtl/csa_seq_adder.sv
// Chunk-serial wide adder. Operands are captured on the accepting edge and
// added CHUNK_W bits per clock through one shared conditional-sum adder,
// LSB chunk first, with a registered carry between chunks. sum/co update
// only on the completing edge so the consumer never sees a partial result.
module csa_seq_adder
   import csa_seq_adder_pkg::*;
#(
   parameter int CHUNK_W    = 4,
   parameter int NUM_CHUNKS = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [CHUNK_W*NUM_CHUNKS-1:0] a,
   input  logic [CHUNK_W*NUM_CHUNKS-1:0] b,
   input  logic                          ci,
   output logic                          busy,
   output logic                          done,
   output logic [CHUNK_W*NUM_CHUNKS-1:0] sum,
   output logic                          co
);

   localparam int            W          = CHUNK_W * NUM_CHUNKS;
   localparam int            IW         = idx_width(NUM_CHUNKS);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_CHUNKS - 1);
   localparam logic [W-1:0]  CHUNK_MASK = W'({CHUNK_W{1'b1}});

   state_t               state;
   state_t               state_nxt;
   logic   [W-1:0]       a_reg;
   logic   [W-1:0]       b_reg;
   logic                 carry_reg;
   logic   [IW-1:0]      idx;
   logic   [W-1:0]       work_sum;
   logic   [W-1:0]       work_nxt;
   logic   [CHUNK_W-1:0] a_chunk;
   logic   [CHUNK_W-1:0] b_chunk;
   logic   [CHUNK_W-1:0] chunk_sum;
   logic                 chunk_co;
   logic                 accept;
   logic                 last;
   int                   shamt;

   // A new operation is taken only when not mid-run.
   always_comb begin
      accept = start && ((state == ST_IDLE) || (state == ST_DONE));
      last   = (idx == IDX_LAST);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; the unused encoding falls back to IDLE.
   always_comb begin
      state_nxt = ST_IDLE;
      case (state)
         ST_IDLE: state_nxt = start ? ST_RUN : ST_IDLE;
         ST_RUN:  state_nxt = last ? ST_DONE : ST_RUN;
         ST_DONE: state_nxt = start ? ST_RUN : ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Status outputs decode the state register only, so start never reaches them.
   always_comb begin
      busy = (state == ST_RUN);
      done = (state == ST_DONE);
   end

   // Chunk select for the shared adder and merge of its result into the
   // working sum (the merged value is also what lands in sum on the last chunk).
   always_comb begin
      shamt    = int'(idx) * CHUNK_W;
      a_chunk  = CHUNK_W'(a_reg >> shamt);
      b_chunk  = CHUNK_W'(b_reg >> shamt);
      work_nxt = (work_sum & ~(CHUNK_MASK << shamt)) | (W'(chunk_sum) << shamt);
   end

   csa_seq_adder_csa #(
      .N (CHUNK_W)
   ) u_csa (
      .a   (a_chunk),
      .b   (b_chunk),
      .ci  (carry_reg),
      .sum (chunk_sum),
      .co  (chunk_co)
   );

   // Operand capture, per-chunk accumulation and result publication.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg     <= '0;
         b_reg     <= '0;
         carry_reg <= 1'b0;
         idx       <= '0;
         work_sum  <= '0;
         sum       <= '0;
         co        <= 1'b0;
      end else if (accept) begin
         a_reg     <= a;
         b_reg     <= b;
         carry_reg <= ci;
         idx       <= '0;
         work_sum  <= '0;
      end else if (state == ST_RUN) begin
         work_sum  <= work_nxt;
         carry_reg <= chunk_co;
         idx       <= last ? '0 : idx + 1'b1;
         if (last) begin
            sum <= work_nxt;
            co  <= chunk_co;
         end
      end
   end

endmodule

// File: tb/tb_csa_seq_adder.sv
// Bench for csa_seq_adder: directed handshake/abort cases on a 4x4 build and
// a random sweep over four geometries against an a+b+ci reference.
module tb_csa_seq_adder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        st [4];
   logic [15:0] aa [4];
   logic [15:0] bb [4];
   logic        cis [4];
   logic        busy_v [4];
   logic        done_v [4];
   logic        co_v [4];
   logic [15:0] sum_v [4];
   logic [15:0] s0;
   logic [7:0]  s1;
   logic [7:0]  s2;
   logic [14:0] s3;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   always_comb begin
      sum_v[0] = s0;
      sum_v[1] = 16'(s1);
      sum_v[2] = 16'(s2);
      sum_v[3] = 16'(s3);
   end

   csa_seq_adder #(.CHUNK_W(4), .NUM_CHUNKS(4)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(st[0]), .a(aa[0]), .b(bb[0]), .ci(cis[0]),
      .busy(busy_v[0]), .done(done_v[0]), .sum(s0), .co(co_v[0]));
   csa_seq_adder #(.CHUNK_W(1), .NUM_CHUNKS(8)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(st[1]), .a(aa[1][7:0]), .b(bb[1][7:0]), .ci(cis[1]),
      .busy(busy_v[1]), .done(done_v[1]), .sum(s1), .co(co_v[1]));
   csa_seq_adder #(.CHUNK_W(8), .NUM_CHUNKS(1)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(st[2]), .a(aa[2][7:0]), .b(bb[2][7:0]), .ci(cis[2]),
      .busy(busy_v[2]), .done(done_v[2]), .sum(s2), .co(co_v[2]));
   csa_seq_adder #(.CHUNK_W(3), .NUM_CHUNKS(5)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(st[3]), .a(aa[3][14:0]), .b(bb[3][14:0]), .ci(cis[3]),
      .busy(busy_v[3]), .done(done_v[3]), .sum(s3), .co(co_v[3]));

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One operation on unit u (width w, n chunks), compared with plain a+b+ci.
   task automatic run_op(input int u, input int w, input int n,
                         input logic [15:0] av, input logic [15:0] bv, input logic civ);
      longint m;
      longint full;
      int     lat;
      int     busy_cnt;
      bit     seen;
      m        = (longint'(1) << w) - 1;
      full     = (longint'(av) & m) + (longint'(bv) & m) + longint'(civ);
      lat      = 0;
      busy_cnt = 0;
      seen     = 0;
      @(negedge clk);
      aa[u] = av; bb[u] = bv; cis[u] = civ; st[u] = 1'b1;
      @(posedge clk);
      #1;
      st[u]  = 1'b0;
      aa[u]  = 16'($urandom);
      bb[u]  = 16'($urandom);
      cis[u] = 1'($urandom);
      for (int c = 1; c <= n + 4 && !seen; c++) begin
         @(negedge clk);
         if (done_v[u]) begin
            seen = 1;
            lat  = c;
         end else if (busy_v[u]) begin
            busy_cnt++;
         end
      end
      check($sformatf("u%0d latency", u), lat, n + 1);
      check($sformatf("u%0d busy_cycles", u), busy_cnt, n);
      check($sformatf("u%0d sum", u), longint'(sum_v[u]) & m, full & m);
      check($sformatf("u%0d co", u), longint'(co_v[u]), (full >> w) & 1);
      @(negedge clk);
      check($sformatf("u%0d done_one_cycle", u), longint'(done_v[u]), 0);
      check($sformatf("u%0d sum_hold", u), longint'(sum_v[u]) & m, full & m);
   endtask

   initial begin
      int t;
      int prev;
      int ndone;
      for (int u = 0; u < 4; u++) begin
         st[u] = 1'b0; aa[u] = '0; bb[u] = '0; cis[u] = 1'b0;
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Idle after reset
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_outputs", {busy_v[0], done_v[0], co_v[0], sum_v[0]}, 0);
      end

      // Basic and carry-chain cases
      run_op(0, 16, 4, 16'h1234, 16'h4321, 1'b0);
      run_op(0, 16, 4, 16'hFFFF, 16'h0000, 1'b1);
      run_op(0, 16, 4, 16'h8000, 16'h8000, 1'b0);

      // start held high: only DONE cycles accept; operands scrambled otherwise
      @(negedge clk);
      aa[0] = 16'h0001; bb[0] = 16'h0001; cis[0] = 1'b0; st[0] = 1'b1;
      t = 0; prev = 0; ndone = 0;
      while (t < 40 && ndone < 4) begin
         @(negedge clk);
         t++;
         if (done_v[0]) begin
            ndone++;
            check("hs_gap", t - prev, 5);
            check("hs_sum", {co_v[0], sum_v[0]}, 17'h00002);
            prev  = t;
            aa[0] = 16'h0001; bb[0] = 16'h0001; cis[0] = 1'b0;
            if (ndone == 4) st[0] = 1'b0;
         end else begin
            aa[0]  = 16'($urandom);
            bb[0]  = 16'($urandom);
            cis[0] = 1'($urandom);
         end
      end
      check("hs_done_count", ndone, 4);
      @(negedge clk);
      check("hs_back_idle", {busy_v[0], done_v[0]}, 0);

      // Abort mid-run
      @(negedge clk);
      aa[0] = 16'hFFFF; bb[0] = 16'h0001; cis[0] = 1'b0; st[0] = 1'b1;
      @(posedge clk);
      #1 st[0] = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("abort_outputs", {busy_v[0], done_v[0], co_v[0], sum_v[0]}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done_v[0]) ndone++;
      end
      check("abort_no_done", ndone, 0);
      run_op(0, 16, 4, 16'h0003, 16'h0004, 1'b0);

      // Random sweep, all four geometries in parallel
      fork
         for (int i = 0; i < 1000; i++) run_op(0, 16, 4, 16'($urandom), 16'($urandom), 1'($urandom));
         for (int i = 0; i < 1000; i++) run_op(1, 8, 8, 16'($urandom), 16'($urandom), 1'($urandom));
         for (int i = 0; i < 1000; i++) run_op(2, 8, 1, 16'($urandom), 16'($urandom), 1'($urandom));
         for (int i = 0; i < 1000; i++) run_op(3, 15, 5, 16'($urandom), 16'($urandom), 1'($urandom));
      join

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
